// File: rtl/hc595_serial_shifter.sv
// Serial back-end for cascaded 74HC595 display drivers: takes one word per
// vld/rdy handshake, shifts it out MSB-first on dio/sclk, then pulses rclk.
module hc595_serial_shifter #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dat,
    input  logic              vld,
    output logic              rdy,
    output logic              done,
    output logic              sclk,
    output logic              rclk,
    output logic              dio
);

    localparam int PH_W  = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t             state_reg;
    logic [DATA_W-1:0]  shreg_reg;
    logic [BIT_W-1:0]   bit_reg;
    logic [PH_W-1:0]    phase_reg;
    logic               phase_end;

    assign phase_end = (phase_reg == PH_LAST);

    // Every phase (low, high, latch) lasts CLK_DIV cycles; phase_reg restarts at each change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            bit_reg   <= '0;
            phase_reg <= '0;
            rdy       <= 1'b0;
            done      <= 1'b0;
            sclk      <= 1'b0;
            rclk      <= 1'b0;
            dio       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sclk      <= 1'b0;
                    rclk      <= 1'b0;
                    phase_reg <= '0;
                    if (rdy && vld) begin
                        shreg_reg <= dat;
                        dio       <= dat[DATA_W-1];
                        bit_reg   <= BIT_TOP;
                        rdy       <= 1'b0;
                        state_reg <= SHIFT_LO;
                    end else begin
                        rdy <= 1'b1;
                    end
                end
                SHIFT_LO: begin
                    if (phase_end) begin
                        phase_reg <= '0;
                        sclk      <= 1'b1;
                        state_reg <= SHIFT_HI;
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (phase_end) begin
                        phase_reg <= '0;
                        sclk      <= 1'b0;
                        shreg_reg <= {shreg_reg[DATA_W-2:0], 1'b0};
                        if (bit_reg == '0) begin
                            rclk      <= 1'b1;
                            state_reg <= LATCH;
                        end else begin
                            // Next bit goes out together with the falling sclk edge.
                            bit_reg   <= bit_reg - 1'b1;
                            dio       <= shreg_reg[DATA_W-2];
                            state_reg <= SHIFT_LO;
                        end
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        phase_reg <= '0;
                        rclk      <= 1'b0;
                        rdy       <= 1'b1;
                        done      <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hc595_serial_shifter.sv
// Bench for hc595_serial_shifter: a CLK_DIV=4 and a CLK_DIV=1 instance, each
// observed by a 74HC595 model (shift on sclk rise, latch on rclk rise).
module tb_hc595_serial_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dat_s  [2];
    logic        vld_s  [2];
    logic        rdy_s  [2];
    logic        done_s [2];
    logic        sclk_s [2];
    logic        rclk_s [2];
    logic        dio_s  [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hc595_serial_shifter #(.DATA_W(16), .CLK_DIV(4)) dut0 (
        .clk(clk), .rst(rst), .dat(dat_s[0]), .vld(vld_s[0]), .rdy(rdy_s[0]),
        .done(done_s[0]), .sclk(sclk_s[0]), .rclk(rclk_s[0]), .dio(dio_s[0])
    );

    hc595_serial_shifter #(.DATA_W(16), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .dat(dat_s[1]), .vld(vld_s[1]), .rdy(rdy_s[1]),
        .done(done_s[1]), .sclk(sclk_s[1]), .rclk(rclk_s[1]), .dio(dio_s[1])
    );

    function automatic int div_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state per instance.
    bit          prev_sclk [2];
    bit          prev_rclk [2];
    bit          prev_rdy  [2];
    bit          prev_dio  [2];
    logic [31:0] sh595     [2];
    logic [15:0] latched   [2];
    logic [15:0] inflight  [2];
    bit          inflight_v[2];
    bit          counting  [2];
    bit          b2b_mode  [2];
    int          nbits     [2];
    int          hi_cnt    [2];
    int          rw_cnt    [2];
    int          low_cnt   [2];
    int          n_latch   [2];
    int          n_done    [2];
    int          n_sclk    [2];
    int          last_acc  [2];
    int          cyc = 0;

    initial begin
        for (int u = 0; u < 2; u++) begin
            prev_sclk[u] = 0; prev_rclk[u] = 0; prev_rdy[u] = 0; prev_dio[u] = 0;
            sh595[u] = '0; latched[u] = '0; inflight[u] = '0; inflight_v[u] = 0;
            counting[u] = 0; b2b_mode[u] = 0; nbits[u] = 0; hi_cnt[u] = 0;
            rw_cnt[u] = 0; low_cnt[u] = 0; n_latch[u] = 0; n_done[u] = 0;
            n_sclk[u] = 0; last_acc[u] = -1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        for (int u = 0; u < 2; u++) begin
            if (!rst) begin
                inflight_v[u] = 0; counting[u] = 0; nbits[u] = 0;
                hi_cnt[u] = 0; rw_cnt[u] = 0;
            end else begin
                if (sclk_s[u] && !prev_sclk[u]) begin
                    sh595[u] = {sh595[u][30:0], dio_s[u]};
                    nbits[u]++;
                    n_sclk[u]++;
                end
                if (sclk_s[u] && prev_sclk[u])
                    check($sformatf("u%0d_dio_stable_sclk_hi", u), 32'(dio_s[u]), 32'(prev_dio[u]));
                if (sclk_s[u]) hi_cnt[u]++;
                else if (prev_sclk[u]) begin
                    check($sformatf("u%0d_sclk_hi_width", u), 32'(hi_cnt[u]), 32'(div_of(u)));
                    hi_cnt[u] = 0;
                end
                if (rclk_s[u] && !prev_rclk[u]) begin
                    check($sformatf("u%0d_rclk_while_sclk", u), 32'(sclk_s[u]), 32'd0);
                    check($sformatf("u%0d_bits_per_xfer", u), 32'(nbits[u]), 32'd16);
                    check($sformatf("u%0d_latch_has_word", u), 32'(inflight_v[u]), 32'd1);
                    check($sformatf("u%0d_latched_word", u), 32'(sh595[u][15:0]), 32'(inflight[u]));
                    latched[u] = sh595[u][15:0];
                    n_latch[u]++;
                    inflight_v[u] = 0;
                end
                if (rclk_s[u]) rw_cnt[u]++;
                else if (prev_rclk[u]) begin
                    check($sformatf("u%0d_rclk_width", u), 32'(rw_cnt[u]), 32'(div_of(u)));
                    rw_cnt[u] = 0;
                end
                if (done_s[u]) n_done[u]++;
                if (!rdy_s[u] && counting[u]) low_cnt[u]++;
                if (rdy_s[u] && !prev_rdy[u] && counting[u]) begin
                    check($sformatf("u%0d_rdy_low_len", u), 32'(low_cnt[u]), 32'(33 * div_of(u)));
                    check($sformatf("u%0d_done_with_rdy", u), 32'(done_s[u]), 32'd1);
                    counting[u] = 0;
                end
                if (rdy_s[u] && vld_s[u]) begin
                    if (b2b_mode[u] && last_acc[u] >= 0)
                        check($sformatf("u%0d_b2b_gap", u), 32'(cyc - last_acc[u]), 32'(33 * div_of(u) + 1));
                    last_acc[u] = cyc;
                    inflight[u] = dat_s[u]; inflight_v[u] = 1;
                    nbits[u] = 0; low_cnt[u] = 0; counting[u] = 1;
                end
            end
            prev_sclk[u] = sclk_s[u];
            prev_rclk[u] = rclk_s[u];
            prev_rdy[u]  = rdy_s[u];
            prev_dio[u]  = dio_s[u];
        end
    end

    // All stimulus tasks are entered and left one step after a rising clk edge.
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input int u, input logic [15:0] w, input bit hold);
        bit ok = 0;
        dat_s[u] = w;
        vld_s[u] = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (rdy_s[u]) begin
                step();
                ok = 1;
                break;
            end
            step();
        end
        if (!hold) vld_s[u] = 1'b0;
        if (!ok) check($sformatf("u%0d_accept_timeout", u), 32'd0, 32'd1);
    endtask

    task automatic wait_latch(input int u, input int target);
        for (int i = 0; i < 3000 && n_latch[u] < target; i++) step();
        if (n_latch[u] < target) check($sformatf("u%0d_latch_timeout", u), 32'(n_latch[u]), 32'(target));
    endtask

    task automatic wait_rdy(input int u);
        for (int i = 0; i < 400 && !rdy_s[u]; i++) step();
        @(negedge clk); #1;
        step();
    endtask

    task automatic xfer(input int u, input logic [15:0] w);
        int l0 = n_latch[u];
        int d0 = n_done[u];
        int s0 = n_sclk[u];
        send(u, w, 1'b0);
        wait_latch(u, l0 + 1);
        wait_rdy(u);
        check($sformatf("u%0d_word_%04h", u, w), 32'(latched[u]), 32'(w));
        check($sformatf("u%0d_done_count", u), 32'(n_done[u] - d0), 32'd1);
        check($sformatf("u%0d_sclk_edges", u), 32'(n_sclk[u] - s0), 32'd16);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0;
        logic [15:0] w;
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            dat_s[u] = '0;
            vld_s[u] = 1'b0;
        end
        #23;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d_rst_rdy", u),  32'(rdy_s[u]),  32'd0);
            check($sformatf("u%0d_rst_done", u), 32'(done_s[u]), 32'd0);
            check($sformatf("u%0d_rst_sclk", u), 32'(sclk_s[u]), 32'd0);
            check($sformatf("u%0d_rst_rclk", u), 32'(rclk_s[u]), 32'd0);
            check($sformatf("u%0d_rst_dio", u),  32'(dio_s[u]),  32'd0);
        end
        step();
        rst = 1'b1;
        check("u0_rdy_before_edge", 32'(rdy_s[0]), 32'd0);
        step();
        check("u0_rdy_first_edge", 32'(rdy_s[0]), 32'd1);
        check("u1_rdy_first_edge", 32'(rdy_s[1]), 32'd1);
        repeat (20) step();
        check("idle_sclk_edges", 32'(n_sclk[0] + n_sclk[1]), 32'd0);
        check("idle_latches", 32'(n_latch[0] + n_latch[1]), 32'd0);

        xfer(0, 16'hC001);

        for (int k = 0; k < 6; k++) begin
            xfer(0, 16'($urandom));
            repeat ($urandom_range(0, 5)) step();
        end
        for (int k = 0; k < 4; k++) begin
            xfer(1, 16'($urandom));
            repeat ($urandom_range(0, 3)) step();
        end

        // Back-to-back: vld never drops, a new word is offered right after each accept.
        b2b_mode[0] = 1;
        last_acc[0] = -1;
        l0 = n_latch[0];
        for (int k = 0; k < 8; k++) begin
            w = {8'($urandom), 8'(1 << k)};
            send(0, w, 1'b1);
        end
        vld_s[0] = 1'b0;
        wait_latch(0, l0 + 8);
        wait_rdy(0);
        b2b_mode[0] = 0;
        check("b2b_latch_count", 32'(n_latch[0] - l0), 32'd8);
        check("b2b_last_word", 32'(latched[0]), 32'(w));

        // New data and vld activity while busy must not disturb the running word.
        l0 = n_latch[0];
        send(0, 16'h0000, 1'b0);
        repeat (39) step();
        dat_s[0] = 16'hFFFF;
        for (int k = 0; k < 20; k++) begin
            vld_s[0] = 1'($urandom);
            step();
        end
        send(0, 16'hFFFF, 1'b0);
        check("mid_first_latched", 32'(n_latch[0] - l0), 32'd1);
        check("mid_word_zero", 32'(latched[0]), 32'h0000);
        wait_latch(0, l0 + 2);
        wait_rdy(0);
        check("mid_second_word", 32'(latched[0]), 32'hFFFF);

        // Reset in the middle of a transfer.
        l0 = n_latch[0];
        send(0, 16'hA5A5, 1'b0);
        repeat (59) step();
        #2 rst = 1'b0;
        #1;
        check("arst_sclk", 32'(sclk_s[0]), 32'd0);
        check("arst_dio",  32'(dio_s[0]),  32'd0);
        check("arst_rdy",  32'(rdy_s[0]),  32'd0);
        check("arst_rclk", 32'(rclk_s[0]), 32'd0);
        repeat (3) step();
        rst = 1'b1;
        repeat (150) step();
        check("arst_no_latch", 32'(n_latch[0] - l0), 32'd0);
        xfer(0, 16'h1234);

        xfer(1, 16'h8001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
